prime_generator: RTL and testbench

- Sequential producer of prime numbers: on a start pulse it scans upward from a seed value and emits every prime up to 2^WIDTH-1, one per valid/ready transfer.
- Output primality is decided by iterative trial division, one divisor per clock.
- It is the generator counterpart of the combinational primality checker. It feeds downstream consumers such as that checker, scoreboards and display logic.

---
 rtl/prime_generator.sv | 132 +++++++++++++
 tb/tb_prime_generator.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_generator.sv
// Sequential prime generator: scans upward from a seed and emits each prime by trial division.
// Optional PRIME_GEN_COUNT_EN adds a saturating prime_count output.
module prime_generator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] start_value,
  output logic [WIDTH-1:0] prime_out,
  output logic             prime_valid,
  input  logic             prime_ready,
  output logic             busy,
  output logic             done
`ifdef PRIME_GEN_COUNT_EN
  ,
  output logic [WIDTH-1:0] prime_count
`endif
);

  // Handshake: a prime transfers on any rising edge where prime_valid & prime_ready;
  // prime_out and prime_valid stay frozen until that edge.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TEST = 2'd1,
    S_EMIT = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO  = WIDTH'(2);

  state_t           r_state;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_div;

  logic [2*WIDTH-1:0] w_div_ext;
  logic [2*WIDTH-1:0] w_cand_ext;
  logic [2*WIDTH-1:0] w_div_sq;
  logic [WIDTH-1:0]   w_rem;
  logic               w_is_prime;
  logic               w_is_comp;
  logic               w_is_max;
  logic               w_accept;

  // Square at double width so the termination test can never overflow.
  assign w_div_ext  = {{WIDTH{1'b0}}, r_div};
  assign w_cand_ext = {{WIDTH{1'b0}}, r_cand};
  assign w_div_sq   = w_div_ext * w_div_ext;
  assign w_rem      = r_cand % r_div;
  assign w_is_prime = (w_div_sq > w_cand_ext);
  assign w_is_comp  = (w_rem == '0);
  assign w_is_max   = (r_cand == MAXV);
  assign w_accept   = (r_state == S_EMIT) && prime_valid && prime_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cand      <= '0;
      r_div       <= TWO;
      prime_out   <= '0;
      prime_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cand  <= (start_value < TWO) ? TWO : start_value;
            r_div   <= TWO;
            busy    <= 1'b1;
            r_state <= S_TEST;
          end
        end
        S_TEST: begin
          if (w_is_prime) begin
            prime_out   <= r_cand;
            prime_valid <= 1'b1;
            r_state     <= S_EMIT;
          end else if (w_is_comp) begin
            if (w_is_max) begin
              done    <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_cand <= r_cand + ONE;
              r_div  <= TWO;
            end
          end else begin
            r_div <= r_div + ONE;
          end
        end
        S_EMIT: begin
          if (w_accept) begin
            prime_valid <= 1'b0;
            if (w_is_max) begin
              done    <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_cand  <= r_cand + ONE;
              r_div   <= TWO;
              r_state <= S_TEST;
            end
          end
        end
        S_FIN: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PRIME_GEN_COUNT_EN
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_count <= '0;
    end else if (w_accept && (r_count != MAXV)) begin
      r_count <= r_count + ONE;
    end
  end

  assign prime_count = r_count;
`endif

endmodule

// File: tb/tb_prime_generator.sv
// Directed bench for prime_generator: table of seeds with hand-computed results plus
// hand-written sequences for latency, back-pressure, mid-scan reset and FIN/start overlap.
`timescale 1ns/1ps
module tb_prime_generator;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] start_value = '0;
  logic         prime_ready = 1'b0;
  logic [W-1:0] prime_out;
  logic         prime_valid;
  logic         busy;
  logic         done;
`ifdef PRIME_GEN_COUNT_EN
  logic [W-1:0] prime_count;
`endif

  prime_generator #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_value (start_value),
    .prime_out   (prime_out),
    .prime_valid (prime_valid),
    .prime_ready (prime_ready),
    .busy        (busy),
    .done        (done)
`ifdef PRIME_GEN_COUNT_EN
    ,
    .prime_count (prime_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [W-1:0] exp_q[$];

  // mode: 0 = ready held high, 1 = random ready, 2 = ready high + start re-pulsed while busy
  typedef struct {
    int seed;
    int mode;
    int first;
    int count;
    int last;
    int done_cyc;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic fail_now(input string name, input int got);
    n_total++;
    $display("FAIL %s: got %0d, nothing was expected", name, got);
  endtask

  function automatic bit is_prime_ref(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d < n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    prime_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (prime_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) fail_now("wait_valid_timeout", budget);
  endtask

  // driver + scoreboard for one complete scan
  task automatic run_scan(input int seed, input int mode,
                          output int cnt, output int first, output int last, output int dcyc);
    int cyc;
    bit held;
    bit finished;
    logic [W-1:0] held_v;
    logic [W-1:0] e;
    cnt = 0; first = -1; last = -1; dcyc = -1;
    held = 1'b0; held_v = '0; finished = 1'b0;
    exp_q.delete();
    for (int n = (seed < 2) ? 2 : seed; n <= 255; n++)
      if (is_prime_ref(n)) exp_q.push_back(W'(n));

    start_value = W'(seed);
    start = 1'b1;
    prime_ready = (mode != 1);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    check("busy_after_start", busy, 1);
`ifdef PRIME_GEN_COUNT_EN
    check("count_cleared_on_start", prime_count, 0);
`endif
    while (cyc < 6000) begin
      if (held) check("hold_stable", {prime_valid, prime_out}, {1'b1, held_v});
      if (done) begin
        finished = 1'b1;
        break;
      end
      prime_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prime_valid && prime_ready) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          fail_now("extra_transfer", prime_out);
        end else begin
          e = exp_q.pop_front();
          check("prime_seq", prime_out, e);
        end
        if (cnt == 0) first = prime_out;
        last = prime_out;
        cnt++;
      end else begin
        held = prime_valid;
        held_v = prime_out;
      end
      if (mode == 2) begin
        start = ($urandom_range(0, 5) == 0);
        start_value = W'($urandom_range(0, 255));
      end
      @(negedge clk);
      cyc++;
    end
    dcyc = cyc;
    if (!finished) begin
      start = 1'b0;
      fail_now("scan_timeout", cyc);
    end else begin
      // start asserted while FIN returns to IDLE must be ignored
      start = (mode == 2);
      start_value = 8'd2;
      @(negedge clk);
      start = 1'b0;
      check("busy_low_after_done", busy, 0);
      check("done_one_cycle", done, 0);
      check("valid_low_after_done", prime_valid, 0);
      @(negedge clk);
      check("idle_after_fin_start", busy, 0);
    end
    check("queue_drained", exp_q.size(), 0);
    prime_ready = 1'b0;
  endtask

  initial begin
    int cnt, first, last, dcyc;
    bit seen;

    vecs[0] = '{seed: 0,   mode: 0, first: 2,   count: 54, last: 251, done_cyc: 0};
    vecs[1] = '{seed: 250, mode: 0, first: 251, count: 1,  last: 251, done_cyc: 31};
    vecs[2] = '{seed: 255, mode: 0, first: -1,  count: 0,  last: -1,  done_cyc: 2};
    vecs[3] = '{seed: 13,  mode: 1, first: 13,  count: 49, last: 251, done_cyc: 0};
    vecs[4] = '{seed: 200, mode: 1, first: 211, count: 8,  last: 251, done_cyc: 0};
    vecs[5] = '{seed: 2,   mode: 2, first: 2,   count: 54, last: 251, done_cyc: 0};
    vecs[6] = '{seed: 1,   mode: 0, first: 2,   count: 54, last: 251, done_cyc: 0};
    vecs[7] = '{seed: 128, mode: 1, first: 131, count: 23, last: 251, done_cyc: 0};
    vecs[8] = '{seed: 240, mode: 0, first: 241, count: 2,  last: 251, done_cyc: 0};

    #2 rst_n = 1'b0;
    #20;
    check("rst_prime_out", prime_out, 0);
    check("rst_valid", prime_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef PRIME_GEN_COUNT_EN
    check("rst_count", prime_count, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_start_busy", busy, 0);

    // first-prime latency from seed 2
    start_value = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("lat_valid_after_start_edge", prime_valid, 0);
    @(negedge clk);
    check("lat_valid_next_edge", prime_valid, 1);
    check("lat_prime_2", prime_out, 2);
    apply_reset();

    foreach (vecs[i]) begin
      run_scan(vecs[i].seed, vecs[i].mode, cnt, first, last, dcyc);
      check($sformatf("v%0d_count", i), cnt, vecs[i].count);
      check($sformatf("v%0d_first", i), first, vecs[i].first);
      check($sformatf("v%0d_last", i), last, vecs[i].last);
      if (vecs[i].done_cyc != 0) check($sformatf("v%0d_done_cyc", i), dcyc, vecs[i].done_cyc);
`ifdef PRIME_GEN_COUNT_EN
      check($sformatf("v%0d_prime_count", i), prime_count, vecs[i].count);
`endif
    end

    // back-pressure: seed 13 held for 6 cycles, then 17 follows
    apply_reset();
    start_value = 8'd13;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(20, seen);
    if (seen) begin
      for (int i = 0; i < 6; i++) begin
        check("bp_hold_valid", prime_valid, 1);
        check("bp_hold_value", prime_out, 13);
        @(negedge clk);
      end
      prime_ready = 1'b1;
      @(negedge clk);
      prime_ready = 1'b0;
      check("bp_valid_drop", prime_valid, 0);
      wait_valid(40, seen);
      if (seen) check("bp_next_prime", prime_out, 17);
    end
    apply_reset();

    // reset during TEST of 97, then restart from the same seed
    start_value = 8'd97;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", prime_valid, 0);
    check("mid_rst_prime_out", prime_out, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_done", {done, busy, prime_valid}, 0);
    end
    run_scan(97, 0, cnt, first, last, dcyc);
    check("restart_first", first, 97);
    check("restart_count", cnt, 30);
    check("restart_last", last, 251);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
